// File: rtl/conv1_frame_sequencer.sv
// Layer-0 conv controller: loads weights, then streams one frame and
// raises a tagged window strobe for every valid KxK window.
module conv1_frame_sequencer #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 5,
   parameter int NUM_WB = 31
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_req,
   input  logic                     wb_valid,
   input  logic [7:0]               wb_data,
   output logic                     wb_ready,
   output logic                     wt_we,
   output logic [4:0]               wt_addr,
   output logic [7:0]               wt_data,
   output logic                     wts_loaded,
   input  logic                     start,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic                     pix_shift,
   output logic                     valid_out_buf,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
   localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
   localparam logic [4:0]    ADDR_LAST = 5'(NUM_WB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_W,
      S_RUN,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [4:0]    r_addr;
   logic          r_wts_loaded;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          r_all_in;
   logic          r_valid;
   logic [RW-1:0] r_out_row;
   logic [CW-1:0] r_out_col;

   logic          w_load;
   logic          w_run;
   logic          w_pix_ready;
   logic          w_pix_shift;
   logic          w_win;
   logic          w_hs;

   assign w_load      = (r_state == S_LOAD_W);
   assign w_run       = (r_state == S_RUN);
   assign w_hs        = r_valid & out_ready;
   assign w_pix_ready = w_run & ~r_all_in & ~(r_valid & ~out_ready);
   assign w_pix_shift = w_pix_ready & pix_valid;
   assign w_win       = w_pix_shift & (r_row >= ROW_KM1) & (r_col >= COL_KM1);

   assign wb_ready      = w_load;
   assign wt_we         = w_load & wb_valid;
   assign wt_addr       = w_load ? r_addr : 5'd0;
   assign wt_data       = w_load ? wb_data : 8'd0;
   assign wts_loaded    = r_wts_loaded;
   assign pix_ready     = w_pix_ready;
   assign pix_shift     = w_pix_shift;
   assign valid_out_buf = r_valid;
   assign out_row       = r_out_row;
   assign out_col       = r_out_col;
   assign busy          = (r_state != S_IDLE);
   assign frame_done    = (r_state == S_DONE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (load_req)
               w_state_nxt = S_LOAD_W;
            else if (start && r_wts_loaded)
               w_state_nxt = S_RUN;
         end
         S_LOAD_W: begin
            if (wb_valid && r_addr == ADDR_LAST)
               w_state_nxt = S_IDLE;
         end
         S_RUN: begin
            if (r_all_in && w_hs)
               w_state_nxt = S_DONE;
         end
         S_DONE: w_state_nxt = S_IDLE;
      endcase
   end

   // Weight address counter and sticky loaded flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr       <= '0;
         r_wts_loaded <= 1'b0;
      end else begin
         if (r_state == S_IDLE && load_req) begin
            r_addr       <= '0;
            r_wts_loaded <= 1'b0;
         end
         if (wt_we) begin
            if (r_addr == ADDR_LAST) begin
               r_addr       <= '0;
               r_wts_loaded <= 1'b1;
            end else begin
               r_addr <= r_addr + 5'd1;
            end
         end
      end
   end

   // Pixel raster counters; all_in marks the last pixel taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row    <= '0;
         r_col    <= '0;
         r_all_in <= 1'b0;
      end else if (r_state != S_RUN) begin
         r_row    <= '0;
         r_col    <= '0;
         r_all_in <= 1'b0;
      end else if (w_pix_shift) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            if (r_row == ROW_LAST) begin
               r_row    <= '0;
               r_all_in <= 1'b1;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Window strobe and tags, held until downstream accepts
   always_ff @(posedge clk) begin
      if (rst || r_state == S_DONE) begin
         r_valid   <= 1'b0;
         r_out_row <= '0;
         r_out_col <= '0;
      end else if (w_win) begin
         r_valid   <= 1'b1;
         r_out_row <= r_row - ROW_KM1;
         r_out_col <= r_col - COL_KM1;
      end else if (w_hs) begin
         r_valid <= 1'b0;
      end
   end

endmodule
